hazard_ctrl_mc: RTL and testbench

HAZARD_CTRL_MC -- requirements
Module: hazard_ctrl_mc

---
 rtl/hazard_ctrl_mc.sv | 149 ++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: pipeline hazard controller with multi-cycle execute support.
//   Purpose : operand forwarding selects, load-use detection, branch flushes and
//             a small FSM that holds Execute for MC_LAT cycles of a multi-cycle op,
//             plus saturating stall/flush event counters.
//   Ports   : CLK, RESET (async, active-high)
//             Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM/RdW         register addresses
//             RegWriteM/RegWriteW, LoadE, PCSrcE, McStartE  pipeline status
//             ForwardAE/ForwardBE                        operand selects
//             StallF/StallD/StallE, FlushD/FlushE/FlushM pipeline control
//             McBusy/McDoneE                             multi-cycle status
//             StallCnt/FlushCnt                          saturating counters
module hazard_ctrl_mc #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              McStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              McBusy,
  output logic              McDoneE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam int unsigned LatW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [LatW-1:0]   lat_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic              mc_start;
  logic              mc_busy;
  logic              lw;
  logic              m_hit_a, w_hit_a, m_hit_b, w_hit_b;

  // Forwarding: M stage beats W stage; register 0 is never forwarded.
  always_comb begin
    m_hit_a = RegWriteM && (RdM != '0) && (RdM == Rs1E);
    w_hit_a = RegWriteW && (RdW != '0) && (RdW == Rs1E);
    m_hit_b = RegWriteM && (RdM != '0) && (RdM == Rs2E);
    w_hit_b = RegWriteW && (RdW != '0) && (RdW == Rs2E);
    ForwardAE = m_hit_a ? 2'b10 : (w_hit_a ? 2'b01 : 2'b00);
    ForwardBE = m_hit_b ? 2'b10 : (w_hit_b ? 2'b01 : 2'b00);
  end

  assign lw = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // A taken branch in Execute squashes the op instead of starting it.
  assign mc_start = (state_q == StIdle) && McStartE && !PCSrcE && (MC_LAT > 1);
  assign mc_busy  = mc_start || (state_q == StRun);

  // Pipeline control. While the multi-cycle op is busy the instruction in E is
  // the op itself, so it outranks both branch and load-use handling.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    McBusy  = 1'b0;
    McDoneE = 1'b0;
    if (!RESET) begin
      if (mc_busy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
        McBusy = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw && (state_q != StDone)) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      McDoneE = (state_q == StDone) || ((MC_LAT == 1) && McStartE);
    end
  end

  // Occupancy: start cycle + (MC_LAT-2) RUN cycles + one DONE cycle. RUN exits
  // on the cycle the counter steps down to 0, so DONE lands exactly on time.
  // A two-cycle op has no RUN cycles and goes straight to DONE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      lat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mc_start) begin
            if (MC_LAT == 2) begin
              state_q <= StDone;
            end else begin
              state_q   <= StRun;
              lat_cnt_q <= LatW'(MC_LAT - 2);
            end
          end
        end
        StRun: begin
          if (lat_cnt_q <= LatW'(1)) state_q <= StDone;
          if (lat_cnt_q != '0) lat_cnt_q <= lat_cnt_q - LatW'(1);
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((FlushD || FlushE || FlushM) && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: the driver pushes hand-computed
// expectations as it applies each vector; the monitor pops and compares them
// on the falling edge. Three instances share inputs: defaults, CNT_W=4 and
// MC_LAT=1.
module tb_hazard_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       rwm, rww, loade, pcsrce, mcstart;

  logic [1:0]  fa, fb;
  logic        stf, std, ste, fld, fle, flm, busy, done;
  logic [15:0] scnt, fcnt;

  logic [1:0]  s_fa, s_fb;
  logic        s_stf, s_std, s_ste, s_fld, s_fle, s_flm, s_busy, s_done;
  logic [3:0]  s_scnt, s_fcnt;

  logic [1:0]  l_fa, l_fb;
  logic        l_stf, l_std, l_ste, l_fld, l_fle, l_flm, l_busy, l_done;
  logic [15:0] l_scnt, l_fcnt;

  always #5 clk = ~clk;

  hazard_ctrl_mc dut (
    .CLK(clk), .RESET(rst), .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
    .RdE(rde), .RdM(rdm), .RdW(rdw), .RegWriteM(rwm), .RegWriteW(rww),
    .LoadE(loade), .PCSrcE(pcsrce), .McStartE(mcstart),
    .ForwardAE(fa), .ForwardBE(fb), .StallF(stf), .StallD(std), .StallE(ste),
    .FlushD(fld), .FlushE(fle), .FlushM(flm), .McBusy(busy), .McDoneE(done),
    .StallCnt(scnt), .FlushCnt(fcnt)
  );

  hazard_ctrl_mc #(.CNT_W(4)) dut_sat (
    .CLK(clk), .RESET(rst), .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
    .RdE(rde), .RdM(rdm), .RdW(rdw), .RegWriteM(rwm), .RegWriteW(rww),
    .LoadE(loade), .PCSrcE(pcsrce), .McStartE(mcstart),
    .ForwardAE(s_fa), .ForwardBE(s_fb), .StallF(s_stf), .StallD(s_std), .StallE(s_ste),
    .FlushD(s_fld), .FlushE(s_fle), .FlushM(s_flm), .McBusy(s_busy), .McDoneE(s_done),
    .StallCnt(s_scnt), .FlushCnt(s_fcnt)
  );

  hazard_ctrl_mc #(.MC_LAT(1)) dut_l1 (
    .CLK(clk), .RESET(rst), .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
    .RdE(rde), .RdM(rdm), .RdW(rdw), .RegWriteM(rwm), .RegWriteW(rww),
    .LoadE(loade), .PCSrcE(pcsrce), .McStartE(mcstart),
    .ForwardAE(l_fa), .ForwardBE(l_fb), .StallF(l_stf), .StallD(l_std), .StallE(l_ste),
    .FlushD(l_fld), .FlushE(l_fle), .FlushM(l_flm), .McBusy(l_busy), .McDoneE(l_done),
    .StallCnt(l_scnt), .FlushCnt(l_fcnt)
  );

  // kind: 0 fwd {fa,fb}; 1 ctl {StallF,StallD,StallE,FlushD,FlushE,FlushM,McBusy,McDoneE};
  //       2 counters {StallCnt,FlushCnt}; 3 narrow StallCnt; 4 MC_LAT=1 {McDoneE,McBusy,StallE}
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic expect_v(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0; rde = '0; rdm = '0; rdw = '0;
    rwm = 1'b0; rww = 1'b0; loade = 1'b0; pcsrce = 1'b0; mcstart = 1'b0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = {28'd0, fa, fb};
        1:       act = {24'd0, stf, std, ste, fld, fle, flm, busy, done};
        2:       act = {scnt, fcnt};
        3:       act = {28'd0, s_scnt};
        4:       act = {29'd0, l_done, l_busy, l_ste};
        default: act = 'x;
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clr();
    // Held in reset with hazards present: control quiet, forwarding live.
    cyc();
    mcstart = 1'b1; loade = 1'b1; rde = 5'd3; rs1d = 5'd3;
    rwm = 1'b1; rdm = 5'd5; rs1e = 5'd5;
    expect_v(1, 32'h00, "rst_ctl");
    expect_v(2, 32'h0, "rst_cnt");
    expect_v(0, 32'b1000, "rst_fwd");
    expect_v(4, 32'b000, "rst_lat1");
    cyc(); rst = 1'b0; clr();
    expect_v(1, 32'h00, "idle_ctl");

    // Forwarding
    cyc(); rwm = 1'b1; rww = 1'b1; rdm = 5'd5; rdw = 5'd5; rs1e = 5'd5;
    expect_v(0, 32'b1000, "fwd_m_prio");
    cyc(); clr(); rwm = 1'b1; rww = 1'b1;
    expect_v(0, 32'b0000, "fwd_x0");
    cyc(); clr(); rww = 1'b1; rdw = 5'd7; rdm = 5'd7; rs2e = 5'd7; rs1e = 5'd3;
    expect_v(0, 32'b0001, "fwd_w_b");
    cyc(); clr(); rwm = 1'b1; rdm = 5'd4; rww = 1'b1; rdw = 5'd4; rs1e = 5'd4; rs2e = 5'd4;
    expect_v(0, 32'b1010, "fwd_m_both");
    cyc(); clr(); rww = 1'b1; rdw = 5'd9; rs1e = 5'd9; rwm = 1'b1; rdm = 5'd8; rs2e = 5'd8;
    expect_v(0, 32'b0110, "fwd_mix");

    // Load-use
    cyc(); clr(); loade = 1'b1; rde = 5'd3; rs2d = 5'd3;
    expect_v(1, 32'b1100_1000, "lw_ctl");
    expect_v(2, 32'h0, "cnt_pre_lw");
    cyc(); clr(); loade = 1'b1;
    expect_v(1, 32'h00, "lw_x0");
    expect_v(2, {16'd1, 16'd1}, "lw_cnt");
    expect_v(3, 32'd1, "sat_lw");

    // Branch overrides load-use
    cyc(); clr(); loade = 1'b1; rde = 5'd3; rs2d = 5'd3; pcsrce = 1'b1;
    expect_v(1, 32'b0001_1000, "br_lw");
    cyc(); clr();
    expect_v(1, 32'h00, "br_after");
    expect_v(2, {16'd1, 16'd2}, "br_cnt");

    // Multi-cycle op, MC_LAT=4, with a load-use hazard during RUN
    cyc(); rst = 1'b1;
    expect_v(2, 32'h0, "rst2_cnt");
    cyc(); rst = 1'b0; clr(); mcstart = 1'b1;
    expect_v(1, 32'b1110_0110, "mc_c0");
    expect_v(4, 32'b100, "lat1_done");
    cyc(); clr(); loade = 1'b1; rde = 5'd3; rs1d = 5'd3;
    expect_v(1, 32'b1110_0110, "mc_c1_lw");
    expect_v(4, 32'b000, "lat1_idle");
    cyc(); clr();
    expect_v(1, 32'b1110_0110, "mc_c2");
    cyc();
    expect_v(1, 32'b0000_0001, "mc_c3_done");
    cyc();
    expect_v(1, 32'h00, "mc_c4");
    expect_v(2, {16'd3, 16'd3}, "mc_cnt");

    // Reset in RUN cycle 1: op abandoned, no late McDoneE
    cyc(); mcstart = 1'b1;
    expect_v(1, 32'b1110_0110, "mc2_c0");
    cyc(); clr(); rst = 1'b1;
    expect_v(1, 32'h00, "rst_mid_ctl");
    expect_v(2, 32'h0, "rst_mid_cnt");
    expect_v(3, 32'd0, "rst_mid_sat");
    cyc(); rst = 1'b0;
    expect_v(1, 32'h00, "post_rst_0");
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_v(1, 32'h00, "post_rst_n");
    end

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      cyc(); loade = 1'b1; rde = 5'd3; rs1d = 5'd3;
      if (i == 0) expect_v(1, 32'b1100_1000, "sat_lw_ctl");
    end
    cyc(); clr();
    expect_v(3, 32'd15, "sat_15");
    expect_v(2, {16'd20, 16'd20}, "cnt_20");
    for (int i = 0; i < 3; i++) begin
      cyc(); loade = 1'b1; rde = 5'd3; rs1d = 5'd3;
    end
    cyc(); clr();
    expect_v(3, 32'd15, "sat_hold");
    expect_v(2, {16'd23, 16'd23}, "cnt_23");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
